// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_ctrl_pkg
// Shared definitions for the MEM-stage exception controller:
//   - exception type encodings driven to CP0
//   - bit positions inside the per-instruction exception flag vector
//   - CP0 register addresses and the Status/Cause fields used here
//   - controller FSM state encoding
//   - the fixed-priority exception encoder
// -----------------------------------------------------------------------------
package exc_ctrl_pkg;

  localparam int EXC_TYPE_W = 4;

  typedef enum logic [EXC_TYPE_W-1:0] {
    EXC_TYPE_NONE    = 4'h0,
    EXC_TYPE_INT     = 4'h1,
    EXC_TYPE_IF_ADEL = 4'h2,
    EXC_TYPE_RI      = 4'h3,
    EXC_TYPE_OV      = 4'h4,
    EXC_TYPE_BP      = 4'h5,
    EXC_TYPE_SYS     = 4'h6,
    EXC_TYPE_ADEL    = 4'h7,
    EXC_TYPE_ADES    = 4'h8,
    EXC_TYPE_ERET    = 4'h9
  } exc_type_e;

  // mem_exc_flags = {eret, ades, adel, sys, bp, ov, ri, if_adel}
  localparam int FLAG_IF_ADEL = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_BP      = 3;
  localparam int FLAG_SYS     = 4;
  localparam int FLAG_ADEL    = 5;
  localparam int FLAG_ADES    = 6;
  localparam int FLAG_ERET    = 7;

  // CP0 register numbers
  localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

  // Status / Cause field positions
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } exc_state_e;

  // Fixed priority: INT, IF_ADEL, RI, OV, BP, SYS, ADEL, ADES, ERET.
  function automatic exc_type_e exc_prioritise(input logic int_take, input logic [7:0] flags);
    exc_type_e t;
    if (int_take)                    t = EXC_TYPE_INT;
    else if (flags[FLAG_IF_ADEL])    t = EXC_TYPE_IF_ADEL;
    else if (flags[FLAG_RI])         t = EXC_TYPE_RI;
    else if (flags[FLAG_OV])         t = EXC_TYPE_OV;
    else if (flags[FLAG_BP])         t = EXC_TYPE_BP;
    else if (flags[FLAG_SYS])        t = EXC_TYPE_SYS;
    else if (flags[FLAG_ADEL])       t = EXC_TYPE_ADEL;
    else if (flags[FLAG_ADES])       t = EXC_TYPE_ADES;
    else if (flags[FLAG_ERET])       t = EXC_TYPE_ERET;
    else                             t = EXC_TYPE_NONE;
    return t;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// -----------------------------------------------------------------------------
// exc_ctrl_if
// Bundle between the pipeline/CP0 side and the exception controller.
//   master : pipeline/CP0 side (drives MEM-stage info, interrupts, CP0 state,
//            WB MTC0 bypass; receives CP0 write data and PC redirect)
//   slave  : exc_ctrl
// Signals: mem_valid, mem_stall, mem_pc, mem_delayslot, mem_exc_flags,
//          mem_if_addr, mem_ls_addr, int_i, cp0_status, cp0_cause, cp0_epc,
//          wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata  (towards exc_ctrl)
//          exception_type, delayslot_flag, current_pc, badvaddr,
//          flush_o, redirect_vld, redirect_pc     (from exc_ctrl)
// -----------------------------------------------------------------------------
interface exc_ctrl_if;
  import exc_ctrl_pkg::*;

  logic        mem_valid;
  logic        mem_stall;
  logic [31:0] mem_pc;
  logic        mem_delayslot;
  logic [7:0]  mem_exc_flags;
  logic [31:0] mem_if_addr;
  logic [31:0] mem_ls_addr;
  logic [5:0]  int_i;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_waddr;
  logic [31:0] wb_cp0_wdata;

  exc_type_e   exception_type;
  logic        delayslot_flag;
  logic [31:0] current_pc;
  logic [31:0] badvaddr;
  logic        flush_o;
  logic        redirect_vld;
  logic [31:0] redirect_pc;

  modport master (
    output mem_valid, mem_stall, mem_pc, mem_delayslot, mem_exc_flags,
           mem_if_addr, mem_ls_addr, int_i, cp0_status, cp0_cause, cp0_epc,
           wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata,
    input  exception_type, delayslot_flag, current_pc, badvaddr,
           flush_o, redirect_vld, redirect_pc
  );

  modport slave (
    input  mem_valid, mem_stall, mem_pc, mem_delayslot, mem_exc_flags,
           mem_if_addr, mem_ls_addr, int_i, cp0_status, cp0_cause, cp0_epc,
           wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata,
    output exception_type, delayslot_flag, current_pc, badvaddr,
           flush_o, redirect_vld, redirect_pc
  );

endinterface

// File: rtl/exc_ctrl_int_sync.sv
// -----------------------------------------------------------------------------
// exc_ctrl_int_sync
// Samples the external hardware interrupt lines into the clk domain.
// Configuration macro: EXC_INT_SYNC_EN
//   defined   : 2-flop synchroniser, 2-cycle sample latency (asynchronous lines)
//   undefined : single register, 1-cycle latency (lines already synchronous)
// Ports:
//   clk    in  1  clock
//   rst    in  1  synchronous active-high reset (sample registers cleared)
//   i_int  in  6  raw interrupt lines
//   o_int  out 6  sampled interrupt lines
// -----------------------------------------------------------------------------
module exc_ctrl_int_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_int,
  output logic [5:0] o_int
);

`ifdef EXC_INT_SYNC_EN
  logic [5:0] r_int_meta;
  logic [5:0] r_int_sync;

  // two-stage synchroniser for asynchronous interrupt sources
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_meta <= 6'd0;
      r_int_sync <= 6'd0;
    end else begin
      r_int_meta <= i_int;
      r_int_sync <= r_int_meta;
    end
  end

  assign o_int = r_int_sync;
`else
  logic [5:0] r_int_sample;

  // single sample register for clk-synchronous interrupt sources
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_sample <= 6'd0;
    end else begin
      r_int_sample <= i_int;
    end
  end

  assign o_int = r_int_sample;
`endif

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
// MEM-stage exception/interrupt arbiter sitting directly upstream of CP0.
// Prioritises interrupts and per-instruction exception flags of the committing
// MEM instruction, presents the CP0 write data combinationally, and sequences
// the pipeline flush plus PC redirect (exception vector, or EPC for ERET).
// Parameters:
//   EXC_VECTOR   redirect target for every exception except ERET
//   DRAIN_CYCLES squash cycles after the one-cycle flush pulse (0..7)
// Configuration macro: EXC_INT_SYNC_EN (interrupt sampling depth, see
//   exc_ctrl_int_sync).
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-high reset
//   bus  exc_ctrl_if.slave  MEM-stage/CP0 inputs; CP0 write data and
//        registered flush_o / redirect_vld / redirect_pc outputs
// -----------------------------------------------------------------------------
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.slave  bus
);

  // Counter reload so that DRAIN lasts exactly DRAIN_CYCLES cycles.
  localparam logic [2:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 3'd0 : 3'(DRAIN_CYCLES - 1);

  exc_state_e  r_state;
  exc_state_e  w_state_nxt;
  logic [2:0]  r_drain_cnt;
  logic [2:0]  w_drain_cnt_nxt;

  logic        r_flush;
  logic        r_redirect_vld;
  logic [31:0] r_redirect_pc;
  logic        w_flush_nxt;
  logic        w_redirect_vld_nxt;
  logic [31:0] w_redirect_pc_nxt;

  logic [5:0]  w_int_sampled;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_int_pend;
  logic        w_int_take;
  logic        w_commit;
  exc_type_e   w_exc_type;
  logic        w_unused_bits;

  exc_ctrl_int_sync u_int_sync (
    .clk   (clk),
    .rst   (rst),
    .i_int (bus.int_i),
    .o_int (w_int_sampled)
  );

  // An MTC0 still in WB has not reached CP0 yet, so its data overrides the
  // architectural value for the register it targets.
  assign w_status = (bus.wb_cp0_we && (bus.wb_cp0_waddr == CP0_ADDR_STATUS)) ? bus.wb_cp0_wdata : bus.cp0_status;
  assign w_cause  = (bus.wb_cp0_we && (bus.wb_cp0_waddr == CP0_ADDR_CAUSE))  ? bus.wb_cp0_wdata : bus.cp0_cause;
  assign w_epc    = (bus.wb_cp0_we && (bus.wb_cp0_waddr == CP0_ADDR_EPC))    ? bus.wb_cp0_wdata : bus.cp0_epc;

  // HW lines masked by IM[7:2], software lines Cause.IP[1:0] by IM[1:0].
  assign w_int_pend = (|(w_int_sampled & w_status[15:10])) | (|(w_cause[9:8] & w_status[9:8]));
  assign w_int_take = w_int_pend & w_status[STATUS_IE] & ~w_status[STATUS_EXL];

  // Interrupts stay pending as a level until an instruction actually commits.
  assign w_commit   = (r_state == ST_RUN) & bus.mem_valid & ~bus.mem_stall;
  assign w_exc_type = w_commit ? exc_prioritise(w_int_take, bus.mem_exc_flags) : EXC_TYPE_NONE;

  assign bus.exception_type = w_exc_type;
  assign bus.delayslot_flag = bus.mem_delayslot;
  assign bus.current_pc     = bus.mem_pc;
  assign bus.badvaddr       = (w_exc_type == EXC_TYPE_IF_ADEL) ? bus.mem_if_addr : bus.mem_ls_addr;

  assign bus.flush_o      = r_flush;
  assign bus.redirect_vld = r_redirect_vld;
  assign bus.redirect_pc  = r_redirect_pc;

  // Status/Cause bits that this block does not interpret.
  assign w_unused_bits = &{1'b0, w_status[31:16], w_status[7:2], w_cause[31:10], w_cause[7:0]};

  // FSM state register and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_exc_type != EXC_TYPE_NONE) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (DRAIN_CYCLES != 0) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = DRAIN_LOAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 3'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_drain_cnt_nxt = 3'd0;
      end
    endcase
  end

  // FSM output decode; values are registered so flush/redirect track the
  // state being entered
  always_comb begin
    w_flush_nxt        = (w_state_nxt != ST_RUN);
    w_redirect_vld_nxt = (w_state_nxt == ST_FLUSH);
    w_redirect_pc_nxt  = r_redirect_pc;
    if ((r_state == ST_RUN) && (w_state_nxt == ST_FLUSH)) begin
      // ERET returns to EPC without checking Status.EXL
      if (w_exc_type == EXC_TYPE_ERET) begin
        w_redirect_pc_nxt = w_epc;
      end else begin
        w_redirect_pc_nxt = EXC_VECTOR;
      end
    end else begin
      w_redirect_pc_nxt = r_redirect_pc;
    end
  end

  // registered flush / redirect outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush        <= 1'b0;
      r_redirect_vld <= 1'b0;
      r_redirect_pc  <= 32'd0;
    end else begin
      r_flush        <= w_flush_nxt;
      r_redirect_vld <= w_redirect_vld_nxt;
      r_redirect_pc  <= w_redirect_pc_nxt;
    end
  end

endmodule
